// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encodings and defaults for the UART imem loader
//
// Purpose: loader FSM and receiver FSM encodings, default UART bit period.
// Ports: none (package).

package imem_loader_pkg;

    // 50 MHz / 115200 baud
    localparam int CLKS_PER_BIT_DEF = 434;

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_DATA = 3'd1,
        S_WR   = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/imem_uart_loader_uart_rx.sv
// rtl/imem_uart_loader_uart_rx.sv - UART 8N1 byte receiver with start-bit glitch rejection
//
// Purpose: synchronise rx, time bits, deliver one byte per frame.
// Ports:
//   clk, rst (sync, active-low), rx (async serial input, idle high)
//   byte_valid - 1-cycle pulse, byte_data holds the received byte
//   byte_data  - last received byte, LSB received first
//   ferr       - 1-cycle pulse when the stop bit reads low

import imem_loader_pkg::*;

module uart_rx #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       ferr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e        st_q;
    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             valid_q;
    logic             ferr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q      <= RX_IDLE;
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            case (st_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        st_q  <= RX_START;
                        cnt_q <= '0;
                    end
                end
                RX_START: begin
                    // Mid-bit re-check: a low pulse shorter than half a bit is ignored.
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        st_q  <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            st_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q <= '0;
                        st_q  <= RX_IDLE;
                        if (rx_sync_q) begin
                            valid_q <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: st_q <= RX_IDLE;
            endcase
        end
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign ferr       = ferr_q;

endmodule

// File: rtl/imem_uart_loader.sv
// rtl/imem_uart_loader.sv - boot loader writing a UART-delivered image into imem
//
// Purpose: receive word count N then N little-endian words, write them to imem
// from address 0, hold the core in reset until the image is complete.
// Ports:
//   clk, rst (sync, active-low), rx (UART in), reload (restart from DONE/ERR)
//   imem_wr_en / imem_addr / imem_data_in - imem write port
//   core_rst_n   - core reset, released only in DONE
//   load_done, load_err - status flags
//   words_loaded - words written so far

import imem_loader_pkg::*;

module imem_uart_loader #(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int ADDR_W       = 10,
    parameter int MAX_WORDS    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              reload,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data_in,
    output logic              core_rst_n,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [31:0] MAX_W32 = 32'(MAX_WORDS);

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        ferr;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .ferr       (ferr)
    );

    state_e            state_q;
    logic [1:0]        idx_q;
    logic [31:0]       asm_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   words_q;
    logic [31:0]       data_q;
    logic              wr_en_q;
    logic              core_rst_n_q;
    logic              done_q;
    logic              err_q;

    // Bytes shift in from the top so the first byte lands in bits 7:0.
    logic [31:0]       word_d;
    logic [ADDR_W:0]   words_inc_d;
    assign word_d      = {byte_data, asm_q[31:8]};
    assign words_inc_d = words_q + (ADDR_W+1)'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_HDR;
            idx_q        <= '0;
            asm_q        <= '0;
            n_q          <= '0;
            addr_q       <= '0;
            words_q      <= '0;
            data_q       <= '0;
            wr_en_q      <= 1'b0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                S_HDR: begin
                    if (ferr) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                        idx_q   <= '0;
                    end else if (byte_valid) begin
                        asm_q <= word_d;
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            if (word_d == 32'd0) begin
                                state_q      <= S_DONE;
                                core_rst_n_q <= 1'b1;
                                done_q       <= 1'b1;
                            end else if (word_d > MAX_W32) begin
                                state_q <= S_ERR;
                                err_q   <= 1'b1;
                            end else begin
                                n_q     <= word_d[ADDR_W:0];
                                state_q <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (ferr) begin
                        // Partial word is dropped; nothing reaches imem.
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                        idx_q   <= '0;
                    end else if (byte_valid) begin
                        asm_q <= word_d;
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            data_q  <= word_d;
                            wr_en_q <= 1'b1;
                            state_q <= S_WR;
                        end
                    end
                end
                S_WR: begin
                    addr_q  <= addr_q + ADDR_W'(1);
                    words_q <= words_inc_d;
                    if (words_inc_d == n_q) begin
                        state_q      <= S_DONE;
                        core_rst_n_q <= 1'b1;
                        done_q       <= 1'b1;
                    end else begin
                        state_q <= S_DATA;
                    end
                end
                S_DONE: begin
                    if (reload) begin
                        state_q      <= S_HDR;
                        core_rst_n_q <= 1'b0;
                        done_q       <= 1'b0;
                        idx_q        <= '0;
                        addr_q       <= '0;
                        words_q      <= '0;
                    end
                end
                S_ERR: begin
                    if (reload) begin
                        state_q <= S_HDR;
                        err_q   <= 1'b0;
                        idx_q   <= '0;
                        addr_q  <= '0;
                        words_q <= '0;
                    end
                end
                default: state_q <= S_HDR;
            endcase
        end
    end

    assign imem_wr_en   = wr_en_q;
    assign imem_addr    = addr_q;
    assign imem_data_in = data_q;
    assign core_rst_n   = core_rst_n_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// tb/tb_imem_uart_loader.sv - self-checking bench for imem_uart_loader

module tb_imem_uart_loader;

    localparam int CPB    = 8;
    localparam int ADDR_W = 4;
    localparam int MAXW   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rx = 1'b1;
    logic              reload = 1'b0;
    logic              imem_wr_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data_in;
    logic              core_rst_n;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;

    always #5 clk = ~clk;

    imem_uart_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_W       (ADDR_W),
        .MAX_WORDS    (MAXW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .reload       (reload),
        .imem_wr_en   (imem_wr_en),
        .imem_addr    (imem_addr),
        .imem_data_in (imem_data_in),
        .core_rst_n   (core_rst_n),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    int total = 0;
    int bad = 0;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic        exp_done;
    logic        exp_err;
    logic [7:0]  tx_q[$];
    int          tx_ferr;

    always @(negedge clk) begin
        if (rst && imem_wr_en) begin
            obs_addr.push_back(32'(imem_addr));
            obs_data.push_back(imem_data_in);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_tx();
        for (int i = 0; i < tx_q.size(); i++) begin
            send_byte(tx_q[i], i != tx_ferr);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx = 1'b1;
        reload = 1'b0;
        rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        obs_addr.delete();
        obs_data.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_reload();
        @(negedge clk) reload = 1'b1;
        @(negedge clk) reload = 1'b0;
    endtask

    function automatic logic [31:0] le_word(input int base);
        return {tx_q[base+3], tx_q[base+2], tx_q[base+1], tx_q[base]};
    endfunction

    // Protocol-level expectation from the byte stream: only bytes ahead of a
    // framing error count; a complete image or a zero count makes later errors moot.
    task automatic model();
        int          len;
        int          comp;
        logic [31:0] n;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        len = (tx_ferr >= 0) ? tx_ferr : tx_q.size();
        if (len < 4) begin
            exp_err = (tx_ferr >= 0);
        end else begin
            n = le_word(0);
            if (n == 0) begin
                exp_done = 1'b1;
            end else if (n > MAXW) begin
                exp_err = 1'b1;
            end else begin
                comp = (len - 4) / 4;
                if (comp > int'(n)) comp = int'(n);
                for (int k = 0; k < comp; k++) begin
                    exp_addr.push_back(32'(k));
                    exp_data.push_back(le_word(4 + 4 * k));
                end
                if (comp == int'(n)) exp_done = 1'b1;
                else if (tx_ferr >= 0) exp_err = 1'b1;
            end
        end
    endtask

    task automatic check_writes(input string tag);
        check({tag, ".nwr"}, 32'(obs_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
            check($sformatf("%s.addr%0d", tag, i), obs_addr[i], exp_addr[i]);
            check($sformatf("%s.data%0d", tag, i), obs_data[i], exp_data[i]);
        end
    endtask

    task automatic check_model(input string tag);
        model();
        check_writes(tag);
        check({tag, ".done"}, 32'(load_done), 32'(exp_done));
        check({tag, ".err"}, 32'(load_err), 32'(exp_err));
        check({tag, ".crn"}, 32'(core_rst_n), 32'(exp_done));
        check({tag, ".words"}, 32'(words_loaded), 32'(exp_addr.size()));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".wr"}, 32'(imem_wr_en), 32'd0);
        check({tag, ".addr"}, 32'(imem_addr), 32'd0);
        check({tag, ".data"}, imem_data_in, 32'd0);
        check({tag, ".crn"}, 32'(core_rst_n), 32'd0);
        check({tag, ".done"}, 32'(load_done), 32'd0);
        check({tag, ".err"}, 32'(load_err), 32'd0);
        check({tag, ".words"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic load_words(input logic [31:0] cnt, input logic [31:0] w0, input logic [31:0] w1, input int nw);
        tx_q.delete();
        tx_ferr = -1;
        for (int i = 0; i < 4; i++) tx_q.push_back(cnt[8*i +: 8]);
        for (int i = 0; i < 4 && nw > 0; i++) tx_q.push_back(w0[8*i +: 8]);
        for (int i = 0; i < 4 && nw > 1; i++) tx_q.push_back(w1[8*i +: 8]);
    endtask

    typedef struct {
        logic [95:0] bytes;
        int          nb;
        int          ferr_at;
        int          exp_writes;
        logic        exp_done;
        logic        exp_err;
        logic        exp_crn;
        int          exp_words;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{{32'h00500593, 32'h00A00513, 32'd2}, 12, -1, 2, 1'b1, 1'b0, 1'b1, 2};
        vecs[1] = '{{64'h0, 32'd0},                       4, -1, 0, 1'b1, 1'b0, 1'b1, 0};
        vecs[2] = '{{64'h0, 32'd9},                       4, -1, 0, 1'b0, 1'b1, 1'b0, 0};
        vecs[3] = '{{32'h88776655, 32'h44332211, 32'd1}, 12,  6, 0, 1'b0, 1'b1, 1'b0, 0};
        vecs[4] = '{{32'h0, 32'hDEADBEEF, 32'd1},         8, -1, 1, 1'b1, 1'b0, 1'b1, 1};
        vecs[5] = '{{32'h0, 32'h12345678, 32'd3},         8, -1, 1, 1'b0, 1'b0, 1'b0, 1};
        vecs[6] = '{{64'h0, 32'd3},                       4,  2, 0, 1'b0, 1'b1, 1'b0, 0};

        // reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // table-driven images
        for (int v = 0; v < 7; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            do_reset();
            tx_q.delete();
            for (int i = 0; i < vecs[v].nb; i++) tx_q.push_back(vecs[v].bytes[8*i +: 8]);
            tx_ferr = vecs[v].ferr_at;
            send_tx();
            model();
            check_writes(tag);
            check({tag, ".nwr_tab"}, 32'(obs_addr.size()), 32'(vecs[v].exp_writes));
            check({tag, ".done"}, 32'(load_done), 32'(vecs[v].exp_done));
            check({tag, ".err"}, 32'(load_err), 32'(vecs[v].exp_err));
            check({tag, ".crn"}, 32'(core_rst_n), 32'(vecs[v].exp_crn));
            check({tag, ".words"}, 32'(words_loaded), 32'(vecs[v].exp_words));
        end

        // overflow, reload from ERR, then load, then reload from DONE
        do_reset();
        load_words(32'd9, 32'h0, 32'h0, 0);
        send_tx();
        check("ovf.err", 32'(load_err), 32'd1);
        check("ovf.crn", 32'(core_rst_n), 32'd0);
        pulse_reload();
        check("ovf.rl_err", 32'(load_err), 32'd0);
        check("ovf.rl_crn", 32'(core_rst_n), 32'd0);
        obs_addr.delete();
        obs_data.delete();
        load_words(32'd1, 32'hCAFEF00D, 32'h0, 1);
        send_tx();
        check_model("ovf.after");
        pulse_reload();
        check("done.rl_done", 32'(load_done), 32'd0);
        check("done.rl_crn", 32'(core_rst_n), 32'd0);
        check("done.rl_words", 32'(words_loaded), 32'd0);

        // reload during DATA is ignored; core held in reset mid-load
        do_reset();
        load_words(32'd1, 32'h0, 32'h0, 0);
        send_tx();
        check("mid.crn", 32'(core_rst_n), 32'd0);
        pulse_reload();
        tx_q.delete();
        tx_ferr = -1;
        for (int i = 0; i < 4; i++) tx_q.push_back(8'(8'hA1 + i));
        send_tx();
        tx_q = {8'h01, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        check_model("rl_in_data");

        // short low glitch while idle, then a normal image
        do_reset();
        @(negedge clk) rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch.nwr", 32'(obs_addr.size()), 32'd0);
        check("glitch.err", 32'(load_err), 32'd0);
        check("glitch.done", 32'(load_done), 32'd0);
        load_words(32'd1, 32'h0BADC0DE, 32'h0, 1);
        send_tx();
        check_model("glitch.after");

        // reset in the middle of the second byte of the second word
        do_reset();
        load_words(32'd2, 32'h11223344, 32'h0, 1);
        tx_q.push_back(8'h55);
        send_tx();
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        check_reset_outputs("midrst");
        repeat (8 * CPB) @(negedge clk);
        obs_addr.delete();
        obs_data.delete();
        load_words(32'd2, 32'h00A00513, 32'h00500593, 2);
        send_tx();
        check_model("midrst.after");

        // randomized images against the protocol model
        for (int r = 0; r < 6; r++) begin
            int n;
            do_reset();
            n = $urandom_range(0, 9);
            tx_q.delete();
            for (int i = 0; i < 4; i++) tx_q.push_back(8'((n >> (8 * i)) & 255));
            if (n <= MAXW) begin
                for (int i = 0; i < 4 * n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
            end
            tx_ferr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, tx_q.size() - 1)) : -1;
            send_tx();
            check_model($sformatf("rnd%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
